arm_motion_ctrl: RTL and testbench
==================================

Name: arm_motion_ctrl

Overview:
- N-joint successor to the two-servo arm controller. Accepts joint-angle targets from the inverse-kinematics solver or from a forced set-point, and clamps them to a safe range.
- Ramps each joint toward its target at a bounded slew per PWM frame, so the arm never jumps.
- Drives one 50 Hz servo PWM per joint plus the gripper PWM. Sits between the inverse solver and the servos.

Parameters:
- N_JOINT, 2, number of arm joints/servo channels.
- FRAME_CNT, 1000000, clk cycles per PWM frame (20 ms at 50 MHz).
- PULSE_MIN, 25000, high cycles at 0 deg (0.5 ms).
- PULSE_PER_DEG, 555, high cycles added per integer degree.
- STEP, 32'h0002_0000, max angle change per frame per joint, Q16.16 deg (2 deg).
- MIN_XITA, 32'h0000_0000, lower clamp, signed Q16.16.
- MAX_XITA, 32'h00B4_0000, upper clamp (180 deg).
- INIT_XITA, 32'h005A_0000, reset angle of every joint (90 deg).
- CATCH_OPEN, 32'h0000_0000, gripper open angle, Q16.16.
- CATCH_CLOSE, 32'h005A_0000, gripper closed angle, Q16.16.

Ports:
- clk  in  1  50 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- ik_xita  in  32*N_JOINT  solver angles, joint i at [32i+31:32i], signed Q16.16.
- ik_valid  in  1  solver result-valid level; its rising edge is used.
- en_ik  in  1  accept solver results.
- en_set  in  1  force set_xita as target (level, priority).
- set_xita  in  32*N_JOINT  forced angles, same packing.
- catch  in  1  1 = close gripper, 0 = open.
- pwm  out  N_JOINT  servo PWM per joint.
- catch_pwm  out  1  gripper PWM.
- cur_xita  out  32*N_JOINT  current commanded angles.
- busy  out  1  high while any joint differs from its target.
- done  out  1  one-cycle pulse when all joints reach their targets.
- clamped  out  1  sticky, set when any loaded target was clamped; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - cur and tgt = INIT_XITA for every joint; state IDLE.
  - pwm = 0, catch_pwm = 0, busy = 0, done = 0, clamped = 0.
  - Frame counter = 0; ik_valid_prev = 0.
  - Duty registers hold the duty for INIT_XITA and CATCH_OPEN.
- Target load, evaluated every cycle:
  - If en_set=1, tgt <= clamp(set_xita).
  - Else if en_ik=1 and ik_valid=1 and ik_valid_prev=0, tgt <= clamp(ik_xita).
  - en_set wins when both are true in the same cycle.
  - A load during MOVE retargets immediately; the ramp continues from cur with no restart.
- Clamp: signed compare per joint against MIN_XITA/MAX_XITA. Any out-of-range joint sets clamped.
- Frame counter:
  - Counts 0..FRAME_CNT-1 and wraps.
  - frame_start = (cnt==0).
- FSM has two states:
  - IDLE: when tgt != cur for any joint, go to MOVE the next cycle and set busy=1.
  - MOVE, on each frame_start, per joint:
    - d = tgt - cur (signed 33-bit).
    - If |d| <= STEP, cur <= tgt; else cur <= cur ± STEP.
    - If after the update all joints equal tgt: done=1 for exactly that cycle, busy=0, go to IDLE.
    - A target loaded on the same cycle as frame_start is seen at the next frame.
- Duty:
  - At frame_start, duty_i <= PULSE_MIN + cur_i[31:16]*PULSE_PER_DEG, using the pre-update cur. This gives a one-frame lag, which is intended and keeps duty glitch-free.
  - cur is never negative because of the clamp; the integer part is truncated.
- PWM:
  - pwm[i] = (cnt < duty_i), registered, so 1 cycle of latency.
  - Duty is only changed at frame_start, so there are no runt pulses.
- Gripper:
  - The catch angle is CATCH_CLOSE or CATCH_OPEN.
  - It is sampled at frame_start and applied directly, with no ramp.
- Reset mid-frame: all outputs drop immediately; the ramp restarts from INIT_XITA after release.

Decomposition:
- Shared header arm_pkg.vh: Q16.16 constants (one degree = 32'h0001_0000), default FRAME_CNT, PULSE_MIN and PULSE_PER_DEG, and the FSM state encodings IDLE/MOVE.
- Sub-module servo_pwm_ch, instantiated N_JOINT+1 times:
  - Inputs: clk, rst_n, cnt, frame_start, xita.
  - Behaviour: latches duty at frame_start and outputs the registered pwm.
  - All channels share one frame counter in the top level.

Test Plan:
- Reset, then run 2 frames -> every pwm high for 25000+90*555=74950 cycles per 1e6; busy=0, cur=0x005A_0000.
- en_set=1 with set_xita={0x0064_0000, 0x0050_0000} (100, 80 deg) -> busy rises; cur moves 2 deg/frame; done pulses exactly once after frame 5; final duties are 80500 and 69400.
- ik_valid held high for 10 cycles with en_ik=1 and ik_xita joint0=0x00C8_0000 (200 deg) -> loads once only; tgt0=0x00B4_0000; clamped=1.
- en_set and the ik_valid rising edge in the same cycle -> set_xita wins; the IK value is ignored.
- Retarget mid-ramp: at cur=96 deg heading to 120, load 90 -> next frame cur=94 with no overshoot; done when cur=90.
- catch toggles mid-frame -> catch_pwm width changes only at the next frame_start (25000 becomes 74950); rst_n low mid-ramp -> pwm=0 immediately and cur=INIT_XITA.

Source files
------------

// File: rtl/arm_motion_ctrl_pkg.sv
// Shared constants for the N-joint arm motion controller: Q16.16 angle scale,
// default PWM timing, FSM encodings and the angle-to-duty conversion.
package arm_motion_ctrl_pkg;

    typedef logic signed [31:0] xita_t;

    localparam logic [31:0] XITA_ONE_DEG      = 32'h0001_0000;
    localparam int          FRAME_CNT_DEF     = 1000000;
    localparam int          PULSE_MIN_DEF     = 25000;
    localparam int          PULSE_PER_DEG_DEF = 555;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MOVE = 1'b1;

    // Integer degrees only; the fractional part of the angle is truncated.
    function automatic logic [31:0] xita_duty(input logic [15:0] deg,
                                              input logic [31:0] pulse_min,
                                              input logic [31:0] pulse_per_deg);
        return pulse_min + {16'd0, deg} * pulse_per_deg;
    endfunction

endpackage

// File: rtl/arm_motion_ctrl_if.sv
// Solver/set-point inputs and servo-side outputs of the arm motion controller.
interface arm_motion_ctrl_if #(
    parameter int N_JOINT = 2
);
    logic [32*N_JOINT-1:0] ik_xita;
    logic                  ik_valid;
    logic                  en_ik;
    logic                  en_set;
    logic [32*N_JOINT-1:0] set_xita;
    logic                  catch;
    logic [N_JOINT-1:0]    pwm;
    logic                  catch_pwm;
    logic [32*N_JOINT-1:0] cur_xita;
    logic                  busy;
    logic                  done;
    logic                  clamped;

    modport master (
        output ik_xita, ik_valid, en_ik, en_set, set_xita, catch,
        input  pwm, catch_pwm, cur_xita, busy, done, clamped
    );

    modport slave (
        input  ik_xita, ik_valid, en_ik, en_set, set_xita, catch,
        output pwm, catch_pwm, cur_xita, busy, done, clamped
    );
endinterface

// File: rtl/arm_motion_ctrl_servo_pwm_ch.sv
// One 50 Hz servo channel: latches its duty at frame start from the supplied
// angle and produces a registered pulse against the shared frame counter.
module servo_pwm_ch
    import arm_motion_ctrl_pkg::*;
#(
    parameter int          PULSE_MIN     = PULSE_MIN_DEF,
    parameter int          PULSE_PER_DEG = PULSE_PER_DEG_DEF,
    parameter logic [31:0] INIT_XITA     = 32'h005A_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cnt,
    input  logic        frame_start,
    input  xita_t       xita,
    output logic        pwm
);
    localparam logic [31:0] P_MIN = 32'(PULSE_MIN);
    localparam logic [31:0] P_DEG = 32'(PULSE_PER_DEG);

    logic [31:0] duty_p0;
    logic        pwm_p1;
    logic [15:0] unused_frac;

    assign unused_frac = xita[15:0];

    // Stage p0: duty only moves at frame start, so no runt pulses mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_p0 <= xita_duty(INIT_XITA[31:16], P_MIN, P_DEG);
        end else if (frame_start) begin
            duty_p0 <= xita_duty(xita[31:16], P_MIN, P_DEG);
        end
    end

    // Stage p1: registered compare, one cycle behind the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_p1 <= 1'b0;
        end else begin
            pwm_p1 <= (cnt < duty_p0);
        end
    end

    assign pwm = pwm_p1;

endmodule

// File: rtl/arm_motion_ctrl.sv
// N-joint arm motion controller: clamps solver/forced targets, slews every
// joint toward its target by at most STEP per PWM frame, drives servo PWMs.
module arm_motion_ctrl
    import arm_motion_ctrl_pkg::*;
#(
    parameter int                 N_JOINT       = 2,
    parameter int                 FRAME_CNT     = FRAME_CNT_DEF,
    parameter int                 PULSE_MIN     = PULSE_MIN_DEF,
    parameter int                 PULSE_PER_DEG = PULSE_PER_DEG_DEF,
    parameter logic signed [31:0] STEP          = 2 * XITA_ONE_DEG,
    parameter logic signed [31:0] MIN_XITA      = 32'h0000_0000,
    parameter logic signed [31:0] MAX_XITA      = 32'h00B4_0000,
    parameter logic signed [31:0] INIT_XITA     = 32'h005A_0000,
    parameter logic signed [31:0] CATCH_OPEN    = 32'h0000_0000,
    parameter logic signed [31:0] CATCH_CLOSE   = 32'h005A_0000
) (
    input logic              clk,
    input logic              rst_n,
    arm_motion_ctrl_if.slave bus
);
    localparam logic [31:0] CNT_LAST = 32'(FRAME_CNT - 1);

    logic [31:0]        cnt;
    logic               frame_start;
    logic [0:0]         state;
    logic               ik_valid_prev;
    logic               busy_r;
    logic               done_r;
    logic               clamped_r;
    logic               load;
    logic               all_hit;
    logic               any_diff;
    xita_t              cur     [N_JOINT];
    xita_t              tgt     [N_JOINT];
    xita_t              cur_nxt [N_JOINT];
    xita_t              ld_xita [N_JOINT];
    logic [N_JOINT-1:0] ld_clip;
    logic [N_JOINT-1:0] pwm_w;
    xita_t              catch_xita;

    function automatic xita_t clamp_xita(input xita_t x);
        if (x < MIN_XITA) return MIN_XITA;
        if (x > MAX_XITA) return MAX_XITA;
        return x;
    endfunction

    // Difference is taken at 33 bits so the slew decision cannot wrap.
    function automatic xita_t slew_xita(input xita_t c, input xita_t t);
        logic signed [32:0] d;
        logic signed [32:0] step_w;
        d      = $signed({t[31], t}) - $signed({c[31], c});
        step_w = $signed({STEP[31], STEP});
        if (d > step_w)  return c + STEP;
        if (d < -step_w) return c - STEP;
        return t;
    endfunction

    assign frame_start = (cnt == 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 32'd0;
        end else begin
            cnt <= (cnt == CNT_LAST) ? 32'd0 : cnt + 32'd1;
        end
    end

    always_comb begin
        load     = bus.en_set | (bus.en_ik & bus.ik_valid & ~ik_valid_prev);
        all_hit  = 1'b1;
        any_diff = 1'b0;
        ld_clip  = '0;
        for (int i = 0; i < N_JOINT; i++) begin
            xita_t src;
            src        = bus.en_set ? $signed(bus.set_xita[32*i +: 32])
                                    : $signed(bus.ik_xita[32*i +: 32]);
            ld_xita[i] = clamp_xita(src);
            ld_clip[i] = (ld_xita[i] != src);
            cur_nxt[i] = slew_xita(cur[i], tgt[i]);
            if (cur_nxt[i] != tgt[i]) all_hit = 1'b0;
            if (cur[i] != tgt[i])     any_diff = 1'b1;
        end
    end

    // Stage p0: target capture and the frame-rate ramp FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ik_valid_prev <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            clamped_r     <= 1'b0;
            for (int i = 0; i < N_JOINT; i++) begin
                cur[i] <= INIT_XITA;
                tgt[i] <= INIT_XITA;
            end
        end else begin
            ik_valid_prev <= bus.ik_valid;
            done_r        <= 1'b0;
            if (load) begin
                for (int i = 0; i < N_JOINT; i++) tgt[i] <= ld_xita[i];
                if (|ld_clip) clamped_r <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (any_diff) begin
                        state  <= ST_MOVE;
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    // tgt here is the pre-load value, so a same-cycle load waits a frame.
                    if (frame_start) begin
                        for (int i = 0; i < N_JOINT; i++) cur[i] <= cur_nxt[i];
                        if (all_hit) begin
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign catch_xita = bus.catch ? CATCH_CLOSE : CATCH_OPEN;

    // Channels see cur before this frame's update: one frame of deliberate lag.
    for (genvar g = 0; g < N_JOINT; g++) begin : g_joint
        servo_pwm_ch #(
            .PULSE_MIN     (PULSE_MIN),
            .PULSE_PER_DEG (PULSE_PER_DEG),
            .INIT_XITA     (INIT_XITA)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .cnt         (cnt),
            .frame_start (frame_start),
            .xita        (cur[g]),
            .pwm         (pwm_w[g])
        );
    end

    servo_pwm_ch #(
        .PULSE_MIN     (PULSE_MIN),
        .PULSE_PER_DEG (PULSE_PER_DEG),
        .INIT_XITA     (CATCH_OPEN)
    ) u_catch (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt         (cnt),
        .frame_start (frame_start),
        .xita        (catch_xita),
        .pwm         (bus.catch_pwm)
    );

    always_comb begin
        bus.cur_xita = '0;
        for (int i = 0; i < N_JOINT; i++) bus.cur_xita[32*i +: 32] = cur[i];
    end

    assign bus.pwm     = pwm_w;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.clamped = clamped_r;

endmodule

// File: tb/tb_arm_motion_ctrl.sv
// Directed bench for arm_motion_ctrl with a shortened frame (500 cycles) and
// scaled pulse timing so the ramp scenarios fit in a short run.
module tb_arm_motion_ctrl;
    localparam int F    = 500;
    localparam int PMIN = 25;
    localparam int PPD  = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   done_base;
    int   run_w  [3] = '{0, 0, 0};
    int   last_w [3] = '{0, 0, 0};
    logic mon_lvl;

    always #5 clk = ~clk;

    arm_motion_ctrl_if #(.N_JOINT(2)) bus ();

    arm_motion_ctrl #(
        .N_JOINT       (2),
        .FRAME_CNT     (F),
        .PULSE_MIN     (PMIN),
        .PULSE_PER_DEG (PPD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] deg(input int d);
        return 32'(d) << 16;
    endfunction

    function automatic int duty(input int d);
        return PMIN + d * PPD;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Pulse widths per channel (2 = gripper) and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
        for (int i = 0; i < 3; i++) begin
            mon_lvl = (i == 2) ? bus.catch_pwm : bus.pwm[i];
            if (mon_lvl === 1'b1) run_w[i]++;
            else if (run_w[i] != 0) begin
                last_w[i] = run_w[i];
                run_w[i]  = 0;
            end
        end
    end

    task automatic wait_cur_change(input string tag);
        logic [63:0] prev;
        logic        hit;
        prev = bus.cur_xita;
        hit  = 1'b0;
        for (int k = 0; k < 2 * F && !hit; k++) begin
            @(negedge clk);
            if (bus.cur_xita !== prev) hit = 1'b1;
        end
        chk(tag, hit, 1);
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < max_cyc && !hit; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) hit = 1'b1;
        end
        chk(tag, hit, 1);
    endtask

    task automatic wait_catch(input string tag, input logic lvl);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 2 * F && !hit; k++) begin
            @(negedge clk);
            if (bus.catch_pwm === lvl) hit = 1'b1;
        end
        chk(tag, hit, 1);
    endtask

    task automatic pulse_set(input int j1, input int j0);
        bus.set_xita = {deg(j1), deg(j0)};
        bus.en_set   = 1'b1;
        @(negedge clk);
        bus.en_set   = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.ik_xita  = '0;
        bus.ik_valid = 1'b0;
        bus.en_ik    = 1'b0;
        bus.en_set   = 1'b0;
        bus.set_xita = '0;
        bus.catch    = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_pwm", bus.pwm, 0);
        chk("rst_catch_pwm", bus.catch_pwm, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_clamped", bus.clamped, 0);
        chk("rst_cur", bus.cur_xita, {deg(90), deg(90)});

        rst_n = 1'b1;
        repeat (F + 400) @(negedge clk);
        chk("idle_w0", last_w[0], duty(90));
        chk("idle_w1", last_w[1], duty(90));
        chk("idle_wc", last_w[2], duty(0));
        chk("idle_busy", bus.busy, 0);
        chk("idle_cur", bus.cur_xita, 64'h005A_0000_005A_0000);

        // Forced set-point ramp: joint1 to 100, joint0 to 80.
        done_base = done_cnt;
        pulse_set(100, 80);
        wait_cur_change("set_chg1");
        chk("set_busy", bus.busy, 1);
        chk("set_cur1", bus.cur_xita, {deg(92), deg(88)});
        wait_cur_change("set_chg2");
        chk("set_cur2", bus.cur_xita, {deg(94), deg(86)});
        wait_done("set_done", 6 * F);
        chk("set_cur_fin", bus.cur_xita, {deg(100), deg(80)});
        repeat (F + 400) @(negedge clk);
        chk("set_done_once", done_cnt - done_base, 1);
        chk("set_busy_fin", bus.busy, 0);
        chk("set_w0", last_w[0], duty(80));
        chk("set_w1", last_w[1], duty(100));
        chk("set_w0_abs", last_w[0], 185);

        // IK load with an over-range joint; later cycles of the level must not reload.
        chk("ik_clamped_pre", bus.clamped, 0);
        done_base    = done_cnt;
        bus.en_ik    = 1'b1;
        bus.ik_xita  = {deg(100), deg(200)};
        bus.ik_valid = 1'b1;
        @(negedge clk);
        bus.ik_xita  = {deg(110), deg(200)};
        repeat (9) @(negedge clk);
        bus.ik_valid = 1'b0;
        chk("ik_clamped", bus.clamped, 1);
        wait_done("ik_done", 55 * F);
        chk("ik_cur_fin", bus.cur_xita, 64'h0064_0000_00B4_0000);

        // en_set and IK rising edge together: the set-point wins.
        @(negedge clk);
        done_base    = done_cnt;
        bus.ik_xita  = {deg(150), deg(20)};
        bus.ik_valid = 1'b1;
        pulse_set(94, 170);
        repeat (3) @(negedge clk);
        bus.ik_valid = 1'b0;
        bus.en_ik    = 1'b0;
        wait_done("prio_done", 8 * F);
        chk("prio_cur", bus.cur_xita, {deg(94), deg(170)});
        repeat (F + 400) @(negedge clk);
        chk("prio_done_once", done_cnt - done_base, 1);

        // Retarget mid-ramp: 94 -> 120, then back to 90 once at 96.
        done_base = done_cnt;
        pulse_set(120, 170);
        wait_cur_change("rt_chg1");
        chk("rt_cur96", bus.cur_xita, {deg(96), deg(170)});
        pulse_set(90, 170);
        wait_cur_change("rt_chg2");
        chk("rt_cur94", bus.cur_xita, {deg(94), deg(170)});
        wait_done("rt_done", 6 * F);
        chk("rt_cur90", bus.cur_xita, {deg(90), deg(170)});
        repeat (F + 400) @(negedge clk);
        chk("rt_done_once", done_cnt - done_base, 1);

        // Gripper closes mid-pulse; width changes only from the next frame.
        wait_catch("cat_rise", 1'b1);
        repeat (5) @(negedge clk);
        bus.catch = 1'b1;
        wait_catch("cat_fall", 1'b0);
        @(negedge clk);
        chk("cat_w_old", last_w[2], duty(0));
        wait_catch("cat_rise2", 1'b1);
        wait_catch("cat_fall2", 1'b0);
        @(negedge clk);
        chk("cat_w_new", last_w[2], duty(90));

        // Reset in the middle of a ramp while the pulses are high.
        pulse_set(120, 170);
        wait_cur_change("rr_chg");
        chk("rr_pwm_pre", bus.pwm, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rr_pwm", bus.pwm, 0);
        chk("rr_catch_pwm", bus.catch_pwm, 0);
        chk("rr_cur", bus.cur_xita, {deg(90), deg(90)});
        chk("rr_busy", bus.busy, 0);
        chk("rr_clamped", bus.clamped, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (F + 400) @(negedge clk);
        chk("rr_cur_after", bus.cur_xita, {deg(90), deg(90)});
        chk("rr_busy_after", bus.busy, 0);
        chk("rr_w1_after", last_w[1], duty(90));
        chk("rr_wc_after", last_w[2], duty(90));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
